keypad_scanner: RTL and testbench

- Drives the row lines of the 4x4 matrix keypad and reads back the column lines.
- Debounces a detected press, encodes it to a 4-bit hex key code, and emits one valid pulse per press.
- Waits for a debounced release before scanning resumes.
- Sits between the keypad pins and the key-consuming logic; it is the driving end of the keypad interface, complementing the column-side debouncer.

---
 rtl/keypad_scanner.sv | 166 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one-hot rows, synchronizes and debounces the
// columns, and emits one key code pulse per debounced press.
module keypad_scanner #(
    parameter int SCAN_DIV   = 16,
    parameter int DEB_CYCLES = 64
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [3:0] columnas,
    output logic [3:0] filas,
    output logic [3:0] tecla,
    output logic       tecla_valida,
    output logic       tecla_presionada
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    localparam logic [1:0] ST_SCAN      = 2'd0;
    localparam logic [1:0] ST_DEB_PRESS = 2'd1;
    localparam logic [1:0] ST_PRESSED   = 2'd2;
    localparam logic [1:0] ST_DEB_REL   = 2'd3;

    logic [1:0]    r_state;
    logic [SW-1:0] r_scan_cnt;
    logic [DW-1:0] r_deb_cnt;
    logic [3:0]    r_sync1;
    logic [3:0]    r_col_s;
    logic [3:0]    r_cap;
    logic [3:0]    r_filas;
    logic [3:0]    r_tecla;
    logic          r_valida;
    logic          r_presionada;
    logic          w_cap_onehot;
    logic [3:0]    w_code;

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Row-major keypad legend; row 3 carries '*'=E, '0', '#'=F, 'D'.
    function automatic logic [3:0] key_map(input logic [3:0] row_oh, input logic [3:0] col_oh);
        logic [3:0] code;
        case ({oh2idx(row_oh), oh2idx(col_oh)})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] rotl(input logic [3:0] f);
        return {f[2:0], f[3]};
    endfunction

    assign w_cap_onehot = (r_cap != 4'b0000) && ((r_cap & (r_cap - 4'b0001)) == 4'b0000);
    assign w_code       = key_map(r_filas, r_cap);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state      <= ST_SCAN;
            r_scan_cnt   <= '0;
            r_deb_cnt    <= '0;
            r_sync1      <= 4'b0000;
            r_col_s      <= 4'b0000;
            r_cap        <= 4'b0000;
            r_filas      <= 4'b0001;
            r_tecla      <= 4'h0;
            r_valida     <= 1'b0;
            r_presionada <= 1'b0;
        end else begin
            r_sync1  <= columnas;
            r_col_s  <= r_sync1;
            r_valida <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    // Column lines need a few cycles to settle after a row change,
                    // so they are only judged at the end of each row slot.
                    if (r_scan_cnt == SCAN_LAST) begin
                        r_scan_cnt <= '0;
                        if (r_col_s == 4'b0000) begin
                            r_filas <= rotl(r_filas);
                        end else begin
                            r_cap     <= r_col_s;
                            r_deb_cnt <= '0;
                            r_state   <= ST_DEB_PRESS;
                        end
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 1'b1;
                    end
                end
                ST_DEB_PRESS: begin
                    if (r_col_s != r_cap) begin
                        r_scan_cnt <= '0;
                        r_deb_cnt  <= '0;
                        r_state    <= ST_SCAN;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_deb_cnt <= '0;
                        r_state   <= ST_PRESSED;
                        // Chords within a row are swallowed: wait for release silently.
                        if (w_cap_onehot) begin
                            r_tecla      <= w_code;
                            r_valida     <= 1'b1;
                            r_presionada <= 1'b1;
                        end
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (r_col_s == 4'b0000) begin
                        r_deb_cnt <= '0;
                        r_state   <= ST_DEB_REL;
                    end
                end
                ST_DEB_REL: begin
                    if (r_col_s != 4'b0000) begin
                        r_deb_cnt <= '0;
                        r_state   <= ST_PRESSED;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_deb_cnt    <= '0;
                        r_scan_cnt   <= '0;
                        r_presionada <= 1'b0;
                        r_filas      <= rotl(r_filas);
                        r_state      <= ST_SCAN;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end
                default: begin
                    r_scan_cnt <= '0;
                    r_deb_cnt  <= '0;
                    r_state    <= ST_SCAN;
                end
            endcase
        end
    end

    assign filas            = r_filas;
    assign tecla            = r_tecla;
    assign tecla_valida     = r_valida;
    assign tecla_presionada = r_presionada;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad matrix model feeds the columns and a
// scoreboard of expected key codes is checked against every tecla_valida pulse.
module tb_keypad_scanner;

    localparam int SCAN_DIV   = 4;
    localparam int DEB_CYCLES = 8;

    logic       clk = 1'b0;
    logic       n_reset = 1'b1;
    logic [3:0] columnas;
    logic [3:0] filas;
    logic [3:0] tecla;
    logic       tecla_valida;
    logic       tecla_presionada;

    logic [3:0] keys [4];
    logic [3:0] sb [$];
    int         n_checks = 0;
    int         n_fails  = 0;
    int         n_pulses = 0;
    logic       prev_valida = 1'b0;

    keypad_scanner #(
        .SCAN_DIV   (SCAN_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk              (clk),
        .n_reset          (n_reset),
        .columnas         (columnas),
        .filas            (filas),
        .tecla            (tecla),
        .tecla_valida     (tecla_valida),
        .tecla_presionada (tecla_presionada)
    );

    always #5 clk = ~clk;

    // A pressed key only shows up on its column while its row is driven.
    always_comb begin
        columnas = 4'b0000;
        for (int r = 0; r < 4; r++)
            if (filas[r] === 1'b1) columnas = columnas | keys[r];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] exp_code;
        if (n_reset) begin
            if (tecla_valida) begin
                n_pulses++;
                n_checks++;
                assert (sb.size() > 0) else begin
                    n_fails++;
                    $error("FAIL unexpected_pulse: observed pulse with tecla %0h, expected no pulse", tecla);
                end
                if (sb.size() > 0) begin
                    exp_code = sb.pop_front();
                    check("pulse_code", 32'(tecla), 32'(exp_code));
                    check("pulse_presionada", 32'(tecla_presionada), 1);
                end
                check("pulse_width", 32'(prev_valida), 0);
            end
            prev_valida = tecla_valida;
        end else begin
            prev_valida = 1'b0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pres(input logic val, input int max, input string tag, output int cyc);
        cyc = 0;
        while (tecla_presionada !== val && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_timeout"}, 32'(tecla_presionada), 32'(val));
    endtask

    task automatic wait_filas(input logic [3:0] val, input int max, input string tag);
        int cyc;
        cyc = 0;
        while (filas !== val && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_timeout"}, 32'(filas), 32'(val));
    endtask

    initial begin
        int         cyc;
        int         p0;
        logic [3:0] tecla_before;

        for (int r = 0; r < 4; r++) keys[r] = 4'b0000;

        // Reset values
        #2 n_reset = 1'b0;
        #1;
        check("rst_filas", 32'(filas), 32'h1);
        check("rst_tecla", 32'(tecla), 0);
        check("rst_valida", 32'(tecla_valida), 0);
        check("rst_presionada", 32'(tecla_presionada), 0);
        cycles(3);
        check("rst_filas_held", 32'(filas), 32'h1);
        n_reset = 1'b1;

        // Idle scan: each row driven for SCAN_DIV cycles, no pulses
        for (int k = 0; k <= 16; k++) begin
            check($sformatf("idle_filas_%0d", k), 32'(filas), 32'(1 << ((k / SCAN_DIV) % 4)));
            check($sformatf("idle_valida_%0d", k), 32'(tecla_valida), 0);
            @(negedge clk);
        end
        check("idle_no_pulses", n_pulses, 0);

        // Clean press of '6' (row1, col2)
        p0 = n_pulses;
        keys[1] = 4'b0100;
        sb.push_back(4'h6);
        wait_pres(1'b1, 100, "key6_press", cyc);
        cycles(30);
        check("key6_tecla", 32'(tecla), 32'h6);
        check("key6_filas_frozen", 32'(filas), 32'h2);
        check("key6_single_pulse", n_pulses - p0, 1);
        keys[1] = 4'b0000;
        wait_pres(1'b0, 40, "key6_release", cyc);
        check("key6_release_len", 32'(cyc >= DEB_CYCLES && cyc <= DEB_CYCLES + 4), 1);
        check("key6_resume_row2", 32'(filas), 32'h4);

        // '#' (row3, col2) with press bounce
        p0 = n_pulses;
        for (int i = 0; i < 3; i++) begin
            keys[3] = 4'b0100;
            cycles(2);
            keys[3] = 4'b0000;
            cycles(2);
        end
        check("hash_bounce_no_pulse", n_pulses - p0, 0);
        keys[3] = 4'b0100;
        sb.push_back(4'hF);
        wait_pres(1'b1, 100, "hash_press", cyc);
        cycles(20);
        check("hash_tecla", 32'(tecla), 32'hF);
        check("hash_single_pulse", n_pulses - p0, 1);
        keys[3] = 4'b0000;
        wait_pres(1'b0, 40, "hash_release", cyc);

        // Long hold of 'A' (row0, col3) with release bounce
        p0 = n_pulses;
        keys[0] = 4'b1000;
        sb.push_back(4'hA);
        wait_pres(1'b1, 100, "keyA_press", cyc);
        cycles(200);
        check("keyA_no_repeat", n_pulses - p0, 1);
        check("keyA_tecla", 32'(tecla), 32'hA);
        check("keyA_filas_frozen", 32'(filas), 32'h1);
        for (int i = 0; i < 2; i++) begin
            keys[0] = 4'b0000;
            cycles(3);
            keys[0] = 4'b1000;
            cycles(4);
            check($sformatf("keyA_bounce_presionada_%0d", i), 32'(tecla_presionada), 1);
        end
        keys[0] = 4'b0000;
        wait_pres(1'b0, 40, "keyA_release", cyc);
        check("keyA_release_len", 32'(cyc >= DEB_CYCLES && cyc <= DEB_CYCLES + 4), 1);
        check("keyA_bounce_no_pulse", n_pulses - p0, 1);
        check("keyA_resume_row1", 32'(filas), 32'h2);

        // Chord '1'+'2' in row0: swallowed
        p0 = n_pulses;
        tecla_before = tecla;
        keys[0] = 4'b0011;
        cycles(80);
        check("chord_no_pulse", n_pulses - p0, 0);
        check("chord_tecla_kept", 32'(tecla), 32'(tecla_before));
        check("chord_presionada", 32'(tecla_presionada), 0);
        check("chord_filas_frozen", 32'(filas), 32'h1);
        keys[0] = 4'b0000;
        wait_filas(4'b0010, 40, "chord_resume");

        // Reset in the middle of debouncing '5' (row1, col1)
        p0 = n_pulses;
        keys[1] = 4'b0010;
        wait_filas(4'b0010, 40, "key5_row");
        cycles(SCAN_DIV + 2);
        check("key5_debouncing_no_pulse", n_pulses - p0, 0);
        n_reset = 1'b0;
        #1;
        check("midrst_filas", 32'(filas), 32'h1);
        check("midrst_tecla", 32'(tecla), 0);
        check("midrst_valida", 32'(tecla_valida), 0);
        check("midrst_presionada", 32'(tecla_presionada), 0);
        cycles(2);
        n_reset = 1'b1;
        sb.push_back(4'h5);
        wait_pres(1'b1, 100, "key5_press", cyc);
        cycles(10);
        check("key5_tecla", 32'(tecla), 32'h5);
        check("key5_single_pulse", n_pulses - p0, 1);
        check("key5_filas", 32'(filas), 32'h2);
        keys[1] = 4'b0000;
        wait_pres(1'b0, 40, "key5_release", cyc);

        cycles(4);
        check("scoreboard_empty", sb.size(), 0);
        check("total_pulses", n_pulses, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
